// File: rtl/mul_add_seq_if.sv
// rtl/mul_add_seq_if.sv - request/result bundle for the multiply-add sequencer
interface mul_add_seq_if;
  logic       start;
  logic [3:0] q;
  logic [3:0] b;
  logic [3:0] r;
  logic       busy;
  logic       done;
  logic [7:0] a;
  logic       err;

  modport master (
    output start,
    output q,
    output b,
    output r,
    input  busy,
    input  done,
    input  a,
    input  err
  );

  modport slave (
    input  start,
    input  q,
    input  b,
    input  r,
    output busy,
    output done,
    output a,
    output err
  );
endinterface

// File: rtl/mul_add_seq.sv
// rtl/mul_add_seq.sv - sequential dividend rebuild a = q*b + r, optional REM_CHECK_EN remainder check
module mul_add_seq (
  input logic          clk,
  input logic          rst_n,
  mul_add_seq_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nxt;

  logic [3:0] q_lat;
  logic [3:0] b_lat;
  logic [3:0] r_lat;
  logic [7:0] acc;
  logic [1:0] step;
  logic [7:0] a_reg;
  logic       done_reg;

  logic       accept;
  logic       last_step;
  logic [7:0] addend;
  logic [7:0] acc_sum;

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode plus the shift-and-add partial product for the current step.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last_step = 1'b0;
    addend    = 8'h00;
    case (state)
      IDLE: begin
        if (bus.start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (q_lat[step]) begin
          addend = {4'b0000, b_lat} << step;
        end
        if (step == 2'd3) begin
          last_step = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    acc_sum = acc + addend;
  end

  // Operand capture, accumulation one quotient bit per cycle, and result publish.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_lat    <= 4'h0;
      b_lat    <= 4'h0;
      r_lat    <= 4'h0;
      acc      <= 8'h00;
      step     <= 2'd0;
      a_reg    <= 8'h00;
      done_reg <= 1'b0;
    end else begin
      done_reg <= last_step;
      if (accept) begin
        q_lat <= bus.q;
        b_lat <= bus.b;
        r_lat <= bus.r;
        acc   <= {4'b0000, bus.r};
        step  <= 2'd0;
      end else if (state == RUN) begin
        acc  <= acc_sum;
        step <= step + 2'd1;
        if (last_step) begin
          a_reg <= acc_sum;
        end
      end
    end
  end

`ifdef REM_CHECK_EN
  logic err_reg;

  // Flag an inconsistent remainder (r >= b, which covers b == 0) alongside done.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_reg <= 1'b0;
    end else if (last_step) begin
      err_reg <= (r_lat >= b_lat);
    end
  end

  assign bus.err = err_reg;
`else
  logic unused_r;
  assign unused_r = ^r_lat;
  assign bus.err  = 1'b0;
`endif

  assign bus.busy = (state != IDLE);
  assign bus.done = done_reg;
  assign bus.a    = a_reg;

endmodule

// File: tb/tb_mul_add_seq.sv
// tb/tb_mul_add_seq.sv - randomized self-checking bench for mul_add_seq
module tb_mul_add_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  mul_add_seq_if bus ();

  mul_add_seq dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int vectors = 0;
  int miscompares = 0;
  int last_a = 0;
  int last_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int ref_err(input int qq, input int bb, input int rr);
    int e;
    e = (rr >= bb) ? 1 : 0;
`ifndef REM_CHECK_EN
    e = 0 * (qq + e);
`endif
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One accepted operation; junk drives start and operands while busy.
  task automatic do_op(input int qq, input int bb, input int rr, input bit junk);
    int ea;
    int ee;
    ea = qq * bb + rr;
    ee = ref_err(qq, bb, rr);
    bus.start = 1'b1;
    bus.q = 4'(qq);
    bus.b = 4'(bb);
    bus.r = 4'(rr);
    tick();
    check("busy_accept", bus.busy, 1);
    check("done_accept", bus.done, 0);
    for (int k = 1; k <= 4; k++) begin
      if (junk) begin
        bus.start = (k == 2) ? 1'b1 : 1'($urandom_range(0, 1));
        bus.q = (k == 2) ? 4'd9 : 4'($urandom);
        bus.b = 4'($urandom);
        bus.r = 4'($urandom);
      end else begin
        bus.start = 1'b0;
      end
      tick();
      if (k < 4) begin
        check("done_run", bus.done, 0);
        check("busy_run", bus.busy, 1);
        check("a_hold_run", bus.a, 32'(last_a));
      end
    end
    check("done_pulse", bus.done, 1);
    check("busy_done", bus.busy, 1);
    check("a_result", bus.a, 32'(ea));
    check("err_result", bus.err, 32'(ee));
    last_a = ea;
    last_err = ee;
    bus.start = junk ? 1'($urandom_range(0, 1)) : 1'b0;
    tick();
    check("done_clear", bus.done, 0);
    check("busy_clear", bus.busy, 0);
    check("a_stable", bus.a, 32'(last_a));
    bus.start = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    bus.start = 1'b0;
    for (int i = 0; i < n; i++) begin
      bus.q = 4'($urandom);
      bus.b = 4'($urandom);
      bus.r = 4'($urandom);
      tick();
      check("idle_busy", bus.busy, 0);
      check("idle_done", bus.done, 0);
      check("idle_a", bus.a, 32'(last_a));
      check("idle_err", bus.err, 32'(last_err));
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.q = 4'h0;
    bus.b = 4'h0;
    bus.r = 4'h0;
    tick();
    tick();
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_a", bus.a, 0);
    check("rst_err", bus.err, 0);
    rst_n = 1'b1;
    idle_cycles(2);

    do_op(15, 1, 0, 1'b0);
    do_op(7, 2, 1, 1'b0);
    do_op(5, 3, 0, 1'b0);
    do_op(3, 4, 3, 1'b0);
    do_op(15, 15, 15, 1'b0);
    do_op(0, 9, 6, 1'b0);
    do_op(2, 3, 0, 1'b1);
    idle_cycles(1);
    do_op(1, 4, 4, 1'b0);
    do_op(1, 0, 0, 1'b0);

    // Abort at RUN step 2, then reset winning over start.
    bus.start = 1'b1;
    bus.q = 4'd2;
    bus.b = 4'd3;
    bus.r = 4'd0;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    check("abort_busy", bus.busy, 0);
    check("abort_done", bus.done, 0);
    check("abort_a", bus.a, 0);
    check("abort_err", bus.err, 0);
    last_a = 0;
    last_err = 0;
    bus.start = 1'b1;
    tick();
    check("rst_prio_busy", bus.busy, 0);
    rst_n = 1'b1;
    idle_cycles(6);
    do_op(6, 7, 2, 1'b0);

    for (int n = 0; n < 40; n++) begin
      do_op(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
            int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) begin
        idle_cycles(int'($urandom_range(1, 3)));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
